// File: rtl/ltc2308_pkg.sv
// LTC2308 controller shared definitions: FSM states,
// default timing and the 6-bit config word layout.
package ltc2308_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  localparam int CONVST_CYCLES_DEF = 2;
  localparam int CONV_CYCLES_DEF   = 64;
  localparam int SCK_EDGES         = 24;
  localparam int DATA_W            = 12;
  localparam int CFG_W             = 6;

  // Bit positions inside the config word, MSB sent first
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  function automatic logic [CFG_W-1:0] cfg_word(
    input logic [3:0] channel,
    input logic       sleep
  );
    logic [CFG_W-1:0] w;
    w          = '0;
    w[CFG_SD]  = ~channel[3];
    w[CFG_OS]  = channel[2];
    w[CFG_S1]  = channel[1];
    w[CFG_S0]  = channel[0];
    w[CFG_UNI] = 1'b1;
    w[CFG_SLP] = sleep;
    return w;
  endfunction

endpackage

// File: rtl/adc_ltc2308.sv
// LTC2308 SPI conversion controller: CONVST pulse, conversion
// wait, 12 SCK periods of config-out / data-in, result strobe.
module adc_ltc2308
  import ltc2308_pkg::*;
#(
  parameter int CONVST_CYCLES = CONVST_CYCLES_DEF,
  parameter int CONV_CYCLES   = CONV_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sleep,
  input  logic [3:0]        channel,
  output logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              CONVST,
  output logic              SCK,
  output logic              SDI,
  input  logic              SDO
);

  localparam logic [7:0] CONVST_LAST = 8'(CONVST_CYCLES - 1);
  localparam logic [7:0] CONV_LAST   = 8'(CONV_CYCLES - 1);
  localparam logic [4:0] SCK_LAST    = 5'(SCK_EDGES - 1);

  state_t state, state_n;

  logic [7:0]        cyc_cnt, cyc_n;
  logic [4:0]        sck_cnt, sck_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [DATA_W-1:0] data_n;
  logic [CFG_W-1:0]  cfg_q, cfg_n;
  logic [CFG_W-1:0]  cfg_sh;
  logic              convst_n;
  logic              sck_o_n;
  logic              sdi_n;
  logic              ready_n;

  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    sck_n   = sck_cnt;
    shift_n = shift_q;
    data_n  = data;
    cfg_n   = cfg_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CONV;
          cyc_n   = '0;
          shift_n = '0;
          cfg_n   = cfg_word(channel, sleep);
        end
      end
      CONV: begin
        if (cyc_cnt == CONVST_LAST) begin
          state_n = WAIT;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 8'd1;
        end
      end
      WAIT: begin
        if (cyc_cnt == CONV_LAST) begin
          state_n = SHIFT;
          cyc_n   = '0;
          sck_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 8'd1;
        end
      end
      SHIFT: begin
        // Odd count = SCK high phase; SDO is stable here
        if (sck_cnt[0]) begin
          shift_n = {shift_q[DATA_W-2:0], SDO};
        end
        if (sck_cnt == SCK_LAST) begin
          state_n = DONE;
          sck_n   = '0;
          data_n  = shift_n;
        end else begin
          sck_n = sck_cnt + 5'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Pins are registered from next state to keep them glitch free
    convst_n = (state_n == CONV);
    sck_o_n  = (state_n == SHIFT) && sck_n[0];
    cfg_sh   = cfg_n << sck_n[4:1];
    sdi_n    = (state_n == SHIFT) && cfg_sh[CFG_W-1];
    ready_n  = (state_n == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      sck_cnt <= '0;
      shift_q <= '0;
      cfg_q   <= '0;
      data    <= '0;
      ready   <= 1'b0;
      CONVST  <= 1'b0;
      SCK     <= 1'b0;
      SDI     <= 1'b0;
    end else begin
      state   <= state_n;
      cyc_cnt <= cyc_n;
      sck_cnt <= sck_n;
      shift_q <= shift_n;
      cfg_q   <= cfg_n;
      data    <= data_n;
      ready   <= ready_n;
      CONVST  <= convst_n;
      SCK     <= sck_o_n;
      SDI     <= sdi_n;
    end
  end

endmodule

// File: tb/tb_adc_ltc2308.sv
// Scoreboard bench for adc_ltc2308 with a behavioural
// LTC2308 model driving SDO and capturing SDI.
module tb_adc_ltc2308;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic        sleep   = 1'b0;
  logic [3:0]  channel = 4'h0;
  logic        ready;
  logic [11:0] data;
  logic        CONVST;
  logic        SCK;
  logic        SDI;
  logic        SDO     = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [11:0] exp_q[$];
  int          ready_cyc[$];
  int          ready_cnt = 0;

  logic [11:0] pat       = 12'h000;
  int          bit_idx   = 11;
  logic        prev_sck  = 1'b0;
  logic [11:0] sdi_bits  = 12'h000;
  int          sck_rises = 0;
  logic        convst_in_shift = 1'b0;

  adc_ltc2308 dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .sleep  (sleep),
    .channel(channel),
    .ready  (ready),
    .data   (data),
    .CONVST (CONVST),
    .SCK    (SCK),
    .SDI    (SDI),
    .SDO    (SDO)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  // ADC model: first bit valid after CONVST, next bit after each SCK fall
  always @(negedge clock) begin
    if (CONVST) begin
      bit_idx   = 11;
      sck_rises = 0;
      sdi_bits  = '0;
    end else if (prev_sck && !SCK && bit_idx > 0) begin
      bit_idx--;
    end
    if (SCK && !prev_sck) begin
      if (sck_rises < 12) sdi_bits[11-sck_rises] = SDI;
      sck_rises++;
    end
    if (CONVST && (SCK || (sck_rises > 0 && sck_rises < 12)))
      convst_in_shift = 1'b1;
    prev_sck = SCK;
    SDO      = pat[bit_idx];
  end

  // Monitor: every ready pulse must match the oldest expected result
  always @(negedge clock) begin
    if (ready) begin
      ready_cnt++;
      ready_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: data %0h, none expected", data);
      end else begin
        check("data", data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int c0;
    int rc0;
    int cv_first;
    int cv_cnt;
    logic any_hi;

    // Reset, asserted between clock edges
    #2 reset = 1'b1;
    #2;
    check("rst_convst", CONVST, 0);
    check("rst_sck", SCK, 0);
    check("rst_sdi", SDI, 0);
    check("rst_ready", ready, 0);
    check("rst_data", data, 12'h000);
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single conversion, config latched at start then inputs changed
    channel = 4'b0101;
    sleep   = 1'b0;
    pat     = 12'hA5A;
    exp_q.push_back(12'hA5A);
    ready_cyc.delete();
    start    = 1'b1;
    c0       = cyc;
    cv_first = 0;
    cv_cnt   = 0;
    for (int rel = 1; rel <= 95; rel++) begin
      tick(1);
      if (CONVST) begin
        if (cv_cnt == 0) cv_first = rel;
        cv_cnt++;
      end
      if (rel == 5) begin
        channel = 4'b1010;
        sleep   = 1'b1;
      end
      if (rel == 40) start = 1'b0;
    end
    check("single_convst_first", cv_first, 1);
    check("single_convst_width", cv_cnt, 2);
    check("single_ready_count", ready_cyc.size(), 1);
    if (ready_cyc.size() > 0)
      check("single_ready_cycle", ready_cyc[0] - c0, 91);
    check("single_sck_periods", sck_rises, 12);
    check("cfg_sdi_bits", sdi_bits, 12'b110110_000000);

    // Start low: pins stay quiet and data holds
    any_hi = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      any_hi = any_hi | CONVST | SCK | SDI;
    end
    check("idle_quiet", any_hi, 0);
    check("idle_ready_count", ready_cnt, 1);
    check("idle_data_hold", data, 12'hA5A);

    // Back-to-back conversions with SDO tied high
    channel = 4'b1000;
    sleep   = 1'b1;
    pat     = 12'hFFF;
    repeat (3) exp_q.push_back(12'hFFF);
    ready_cyc.delete();
    convst_in_shift = 1'b0;
    start = 1'b1;
    c0    = cyc;
    for (int rel = 1; rel <= 300; rel++) begin
      tick(1);
      if (rel == 220) start = 1'b0;
    end
    check("b2b_ready_count", ready_cyc.size(), 3);
    if (ready_cyc.size() == 3) begin
      check("b2b_first", ready_cyc[0] - c0, 91);
      check("b2b_gap1", ready_cyc[1] - ready_cyc[0], 92);
      check("b2b_gap2", ready_cyc[2] - ready_cyc[1], 92);
    end
    check("b2b_convst_in_shift", convst_in_shift, 0);
    check("b2b_sdi_bits", sdi_bits, 12'b000011_000000);

    // Reset in the middle of SHIFT
    channel = 4'b0011;
    sleep   = 1'b0;
    pat     = 12'h3C5;
    start   = 1'b1;
    rc0     = ready_cnt;
    tick(3);
    for (int i = 0; i < 200 && sck_rises < 3; i++) tick(1);
    check("shift_reached", sck_rises >= 3, 1);
    #3 reset = 1'b1;
    #1;
    check("abort_convst", CONVST, 0);
    check("abort_sck", SCK, 0);
    check("abort_sdi", SDI, 0);
    check("abort_ready", ready, 0);
    check("abort_data", data, 12'h000);
    tick(3);
    check("abort_no_ready", ready_cnt, rc0);
    exp_q.push_back(12'h3C5);
    reset = 1'b0;
    tick(1);
    check("restart_convst", CONVST, 1);
    for (int rel = 2; rel <= 100; rel++) begin
      tick(1);
      if (rel == 40) start = 1'b0;
    end
    check("restart_ready_count", ready_cnt, rc0 + 1);
    check("restart_sdi_bits", sdi_bits, 12'b101110_000000);
    check("restart_data_hold", data, 12'h3C5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
